// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider. It produces one quotient bit per clock.
// Handshake: start is sampled only while busy=0, in IDLE or in the DONE cycle.
// An accepted start latches the operands. Later operand changes are ignored.
// busy is high for every RUN cycle.
// done pulses for exactly one cycle, when quotient, remainder and div_zero take
// their new values. Those outputs then hold until the next result.
// busy and done are never high together.
module seq_divider #(
   parameter int DW = 4,
   parameter int VW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero,
   output logic [1:0]    dbg_state_o
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvd_q, dvd_d;     // dividend, shifted out MSB first
   logic [VW-1:0] dvs_q, dvs_d;     // latched divisor
   logic [VW-1:0] pr_q, pr_d;       // partial remainder, always < divisor
   logic [DW-1:0] qw_q, qw_d;       // quotient under construction
   logic [DW-1:0] quo_q, quo_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dz_q, dz_d;

   // One restoring step. The trial value is VW+1 bits wide, so the compare cannot overflow.
   logic [VW:0]   shifted;
   logic          ge;
   logic [VW-1:0] pr_next;
   logic [DW-1:0] q_next;

   // Datapath for a single iteration
   always_comb begin
      shifted = {pr_q, dvd_q[DW-1]};
      ge      = (shifted >= {1'b0, dvs_q});
      pr_next = ge ? VW'(shifted - {1'b0, dvs_q}) : shifted[VW-1:0];
      q_next  = (qw_q << 1) | DW'(ge);
   end

   // Next-state and next-register logic for the IDLE -> RUN -> DONE sequence
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      pr_d    = pr_q;
      qw_d    = qw_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor != '0) begin
                  state_d = S_RUN;
                  dvd_d   = dividend;
                  dvs_d   = divisor;
                  pr_d    = '0;
                  qw_d    = '0;
                  cnt_d   = CW'(DW - 1);
               end else begin
                  // A zero divisor skips RUN. The result is all ones with a zero remainder.
                  state_d = S_DONE;
                  quo_d   = '1;
                  rem_d   = '0;
                  dz_d    = 1'b1;
               end
            end
         end
         S_RUN: begin
            pr_d  = pr_next;
            dvd_d = dvd_q << 1;
            qw_d  = q_next;
            if (cnt_q == '0) begin
               // Publish the result only at this point. The outputs hold during RUN.
               state_d = S_DONE;
               quo_d   = q_next;
               rem_d   = pr_next;
               dz_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers. Reset clears everything and discards any division in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         pr_q    <= '0;
         qw_q    <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         pr_q    <= pr_d;
         qw_q    <= qw_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_zero    = dz_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a DW=4/VW=2 instance and a DW=8/VW=4 instance.
module tb_seq_divider;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // DW=4, VW=2 instance
   logic       a_start;
   logic [3:0] a_dvd;
   logic [1:0] a_dvs;
   logic       a_busy, a_done, a_dz;
   logic [3:0] a_q;
   logic [1:0] a_r;
   logic [1:0] a_st;

   // DW=8, VW=4 instance
   logic       b_start;
   logic [7:0] b_dvd;
   logic [3:0] b_dvs;
   logic       b_busy, b_done, b_dz;
   logic [7:0] b_q;
   logic [3:0] b_r;
   logic [1:0] b_st;

   seq_divider #(.DW(4), .VW(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .dividend(a_dvd), .divisor(a_dvs),
      .busy(a_busy), .done(a_done), .quotient(a_q), .remainder(a_r), .div_zero(a_dz),
      .dbg_state_o(a_st)
   );

   seq_divider #(.DW(8), .VW(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .dividend(b_dvd), .divisor(b_dvs),
      .busy(b_busy), .done(b_done), .quotient(b_q), .remainder(b_r), .div_zero(b_dz),
      .dbg_state_o(b_st)
   );

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_total = 0;
   int last_q  = 0;
   int last_r  = 0;
   int last_dz = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: plain integer division.
   function automatic void ref_div(input int dw, input int d, input int v,
                                   output int q, output int r, output int dz);
      if (v == 0) begin
         q = (1 << dw) - 1; r = 0; dz = 1;
      end else begin
         q = d / v; r = d % v; dz = 0;
      end
   endfunction

   // busy and done must never be high together on either instance.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("a_busy_and_done", int'(a_busy & a_done), 0);
         chk("b_busy_and_done", int'(b_busy & b_done), 0);
      end
   end

   // ---------------- driver tasks (DW=4 instance) ----------------
   task automatic a_start_op(input int d, input int v);
      a_start = 1'b1; a_dvd = 4'(d); a_dvs = 2'(v);
      @(negedge clk);
      a_start = 1'b0;
   endtask

   // Wait for done. While waiting, check that the outputs still hold the last
   // result, and drive random operands to show they are ignored.
   task automatic a_wait_done(input int lat0, output int lat);
      lat = lat0;
      while (!a_done && lat < 40) begin
         chk("a_hold_q", int'(a_q), last_q);
         chk("a_hold_r", int'(a_r), last_r);
         chk("a_hold_dz", int'(a_dz), last_dz);
         a_dvd = 4'($urandom);
         a_dvs = 2'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("a_done_seen", int'(a_done), 1);
   endtask

   task automatic a_do(input string nm, input int d, input int v,
                       input int eq, input int er, input int edz, input int elat);
      int lat;
      a_start_op(d, v);
      a_wait_done(1, lat);
      chk($sformatf("%s q %0d/%0d", nm, d, v), int'(a_q), eq);
      chk($sformatf("%s r %0d/%0d", nm, d, v), int'(a_r), er);
      chk($sformatf("%s dz %0d/%0d", nm, d, v), int'(a_dz), edz);
      chk($sformatf("%s lat %0d/%0d", nm, d, v), lat, elat);
      last_q = eq; last_r = er; last_dz = edz;
   endtask

   task automatic b_do(input int d, input int v, input int eq, input int er,
                       input int edz, input int elat);
      int lat;
      b_start = 1'b1; b_dvd = 8'(d); b_dvs = 4'(v);
      @(negedge clk);
      b_start = 1'b0;
      lat = 1;
      while (!b_done && lat < 40) begin
         b_dvd = 8'($urandom);
         b_dvs = 4'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("b_done_seen", int'(b_done), 1);
      chk($sformatf("b q %0d/%0d", d, v), int'(b_q), eq);
      chk($sformatf("b r %0d/%0d", d, v), int'(b_r), er);
      chk($sformatf("b dz %0d/%0d", d, v), int'(b_dz), edz);
      chk($sformatf("b lat %0d/%0d", d, v), lat, elat);
   endtask

   typedef struct {
      int dvd; int dvs; int q; int r; int dz; int lat;
   } vec_t;
   vec_t tbl[7];

   // ---------------- test sequence ----------------
   initial begin
      int lat, eq, er, edz, seen;

      tbl[0] = '{dvd: 13, dvs: 3, q: 4,  r: 1, dz: 0, lat: 5};
      tbl[1] = '{dvd: 15, dvs: 1, q: 15, r: 0, dz: 0, lat: 5};
      tbl[2] = '{dvd: 2,  dvs: 3, q: 0,  r: 2, dz: 0, lat: 5};
      tbl[3] = '{dvd: 0,  dvs: 2, q: 0,  r: 0, dz: 0, lat: 5};
      tbl[4] = '{dvd: 7,  dvs: 0, q: 15, r: 0, dz: 1, lat: 1};
      tbl[5] = '{dvd: 9,  dvs: 2, q: 4,  r: 1, dz: 0, lat: 5};
      tbl[6] = '{dvd: 3,  dvs: 3, q: 1,  r: 0, dz: 0, lat: 5};

      rst_n = 1'b0;
      a_start = 1'b0; a_dvd = 4'd5; a_dvs = 2'd1;
      b_start = 1'b0; b_dvd = 8'd5; b_dvs = 4'd1;
      repeat (3) @(negedge clk);
      chk("rst a_busy", int'(a_busy), 0);
      chk("rst a_done", int'(a_done), 0);
      chk("rst a_q", int'(a_q), 0);
      chk("rst a_r", int'(a_r), 0);
      chk("rst a_dz", int'(a_dz), 0);
      chk("rst b_busy", int'(b_busy), 0);
      chk("rst b_q", int'(b_q), 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // Directed table. Entry 4 (zero divisor) sets div_zero, and entry 5 clears it.
      for (int i = 0; i < 7; i++) begin
         a_do("tbl", tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat);
         @(negedge clk);
      end

      // A start while busy is ignored. A start on the done cycle is accepted.
      a_start_op(13, 3);
      @(negedge clk);
      a_start = 1'b1; a_dvd = 4'd6; a_dvs = 2'd2;
      @(negedge clk);
      a_start = 1'b0;
      a_wait_done(3, lat);
      chk("busy_ign q", int'(a_q), 4);
      chk("busy_ign r", int'(a_r), 1);
      chk("busy_ign lat", lat, 5);
      last_q = 4; last_r = 1; last_dz = 0;
      a_start_op(6, 2);
      a_wait_done(1, lat);
      chk("b2b q", int'(a_q), 3);
      chk("b2b r", int'(a_r), 0);
      chk("b2b lat", lat, 5);
      last_q = 3; last_r = 0; last_dz = 0;
      @(negedge clk);

      // Assert reset on the 3rd RUN cycle of 11/2.
      a_start_op(11, 2);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst busy", int'(a_busy), 0);
      chk("midrst done", int'(a_done), 0);
      chk("midrst q", int'(a_q), 0);
      chk("midrst r", int'(a_r), 0);
      chk("midrst dz", int'(a_dz), 0);
      last_q = 0; last_r = 0; last_dz = 0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_done) seen++;
      end
      chk("midrst no_done", seen, 0);

      // Sweep every operand pair: compare with the model and check the invariant.
      for (int d = 0; d < 16; d++) begin
         for (int v = 0; v < 4; v++) begin
            ref_div(4, d, v, eq, er, edz);
            a_do("sweep", d, v, eq, er, edz, (v == 0) ? 1 : 5);
            if (v != 0) begin
               chk($sformatf("inv %0d/%0d", d, v), int'(a_q) * v + int'(a_r), d);
               chk($sformatf("rem<div %0d/%0d", d, v), int'(int'(a_r) < v), 1);
            end
         end
      end

      // Random operations, sometimes back-to-back.
      for (int i = 0; i < 150; i++) begin
         int d, v;
         d = $urandom_range(0, 15);
         v = $urandom_range(0, 3);
         ref_div(4, d, v, eq, er, edz);
         a_do("rand", d, v, eq, er, edz, (v == 0) ? 1 : 5);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      // Wider instance: the directed case, a zero divisor, and random operands.
      b_do(200, 7, 28, 4, 0, 9);
      @(negedge clk);
      b_do(77, 0, 255, 0, 1, 1);
      for (int i = 0; i < 40; i++) begin
         int d, v;
         d = $urandom_range(0, 255);
         v = $urandom_range(0, 15);
         ref_div(8, d, v, eq, er, edz);
         b_do(d, v, eq, er, edz, (v == 0) ? 1 : 9);
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
